// File: rtl/l1d_bank_port_arb_if.sv
// Request/response bundle between the requester queues and the L1D bank port arbiter.
// master = requester/bank side, slave = arbiter.
interface l1d_bank_port_arb_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 64
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]           req_vld_i;
  logic [N_REQ-1:0]           req_lock_i;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload_i;
  logic [N_REQ-1:0]           req_rdy_o;
  logic                       out_vld_o;
  logic [PAYLOAD_W-1:0]       out_payload_o;
  logic [IDX_W-1:0]           out_src_o;
  logic                       out_rdy_i;
  logic                       locked_o;

  modport master (
    output req_vld_i, req_lock_i, req_payload_i, out_rdy_i,
    input  req_rdy_o, out_vld_o, out_payload_o, out_src_o, locked_o
  );

  modport slave (
    input  req_vld_i, req_lock_i, req_payload_i, out_rdy_i,
    output req_rdy_o, out_vld_o, out_payload_o, out_src_o, locked_o
  );
endinterface

// File: rtl/l1d_bank_port_arb.sv
// Round-robin L1D bank port arbiter with lockable multi-beat grants and a single registered output stage.
// Optional: L1D_ARB_REQ0_PRIO_EN gives requester 0 (refill) fixed priority outside of locks.
module l1d_bank_port_arb #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 64,
  parameter int IDX_W     = $clog2(N_REQ)
) (
  input logic clk,
  input logic rstn,
  l1d_bank_port_arb_if.slave bus
);

  logic                 r_out_vld;
  logic [PAYLOAD_W-1:0] r_out_payload;
  logic [IDX_W-1:0]     r_out_src;
  logic                 r_locked;
  logic [IDX_W-1:0]     r_lock_idx;
  logic [IDX_W-1:0]     r_rr_ptr;

  logic [N_REQ-1:0]     w_lock_oh;
  logic [N_REQ-1:0]     w_elig;
  logic [N_REQ-1:0]     w_rdy;
  logic [IDX_W-1:0]     w_scan [N_REQ];
  logic [PAYLOAD_W-1:0] w_pay  [N_REQ];
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_next_ptr;
  logic                 w_found;
  logic                 w_can_accept;
  logic                 w_accept;

  // w_scan[k] is the k-th index visited from rr_ptr, wrapped without a divider
  for (genvar k = 0; k < N_REQ; k++) begin : g_scan
    logic [IDX_W:0] w_sum;
    assign w_sum     = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
    assign w_scan[k] = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                                     : IDX_W'(w_sum);
    assign w_pay[k]  = bus.req_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
  end

  always_comb begin
    w_lock_oh             = '0;
    w_lock_oh[r_lock_idx] = 1'b1;
  end

  assign w_elig       = r_locked ? (bus.req_vld_i & w_lock_oh) : bus.req_vld_i;
  assign w_can_accept = ~r_out_vld | bus.out_rdy_i;

  // descending walk so the nearest eligible index after rr_ptr is the last one written
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (w_elig[w_scan[k]]) begin
        w_found = 1'b1;
        w_win   = w_scan[k];
      end
    end
`ifdef L1D_ARB_REQ0_PRIO_EN
    if (w_elig[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_comb begin
    w_rdy = '0;
    if (rstn && w_can_accept && w_found) w_rdy[w_win] = 1'b1;
  end

  assign w_accept   = |(bus.req_vld_i & w_rdy);
  assign w_next_ptr = (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_vld     <= 1'b0;
      r_out_payload <= '0;
      r_out_src     <= '0;
      r_locked      <= 1'b0;
      r_lock_idx    <= '0;
      r_rr_ptr      <= '0;
    end else if (w_accept) begin
      r_out_vld     <= 1'b1;
      r_out_payload <= w_pay[w_win];
      r_out_src     <= w_win;
      r_locked      <= bus.req_lock_i[w_win];
      if (bus.req_lock_i[w_win]) r_lock_idx <= w_win;
`ifdef L1D_ARB_REQ0_PRIO_EN
      // a refill grant does not consume the round-robin turn
      if (w_win != '0) r_rr_ptr <= w_next_ptr;
`else
      r_rr_ptr      <= w_next_ptr;
`endif
    end else if (bus.out_rdy_i) begin
      r_out_vld     <= 1'b0;
    end
  end

  assign bus.req_rdy_o     = w_rdy;
  assign bus.out_vld_o     = r_out_vld;
  assign bus.out_payload_o = r_out_payload;
  assign bus.out_src_o     = r_out_src;
  assign bus.locked_o      = r_locked;

endmodule

// File: tb/tb_l1d_bank_port_arb.sv
// Directed vector bench for l1d_bank_port_arb (N_REQ=4, PAYLOAD_W=64); honours L1D_ARB_REQ0_PRIO_EN.
module tb_l1d_bank_port_arb;

  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  l1d_bank_port_arb_if #(.N_REQ(N), .PAYLOAD_W(W)) bus ();

  l1d_bank_port_arb #(.N_REQ(N), .PAYLOAD_W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] vld;
    logic [3:0] lock;
    logic       ordy;
    logic [3:0] erdy;
    logic       eovld;
    logic [1:0] esrc;
    logic       elocked;
    logic [W-1:0] epay;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [W-1:0] pat(input int i);
    pat = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 32'h0101_0101)};
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] lk, input logic ordy,
                     input logic [3:0] erdy, input logic eovld, input logic [1:0] esrc,
                     input logic elk);
    vec_t t;
    t.rstn = r; t.vld = v; t.lock = lk; t.ordy = ordy;
    t.erdy = erdy; t.eovld = eovld; t.esrc = esrc; t.elocked = elk;
    t.epay = r ? pat(int'(esrc)) : '0;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
      nerr++;
    end
  endtask

  initial begin
    rstn              = 1'b0;
    bus.req_vld_i     = '0;
    bus.req_lock_i    = '0;
    bus.out_rdy_i     = 1'b1;
    bus.req_payload_i = {pat(3), pat(2), pat(1), pat(0)};

    //   rstn vld    lock   ordy erdy   ovld src  lk
    add(0, 4'hF, 4'h0, 1, 4'h0, 0, 2'd0, 0);        // reset state
`ifdef L1D_ARB_REQ0_PRIO_EN
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);        // req0 wins every cycle
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);
    add(1, 4'hE, 4'h0, 1, 4'h2, 1, 2'd1, 0);        // rr_ptr still 0 -> req1
    add(1, 4'h4, 4'h4, 1, 4'h4, 1, 2'd2, 1);        // req2 locks
    add(1, 4'h5, 4'h0, 1, 4'h4, 1, 2'd2, 0);        // req0 cannot break lock
    add(1, 4'h9, 4'h0, 1, 4'h1, 1, 2'd0, 0);        // prio ahead of rr_ptr=3
    add(1, 4'h8, 4'h0, 1, 4'h8, 1, 2'd3, 0);
`else
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);        // all valid: 0,1,2,3,0,1
    add(1, 4'hF, 4'h0, 1, 4'h2, 1, 2'd1, 0);
    add(1, 4'hF, 4'h0, 1, 4'h4, 1, 2'd2, 0);
    add(1, 4'hF, 4'h0, 1, 4'h8, 1, 2'd3, 0);
    add(1, 4'hF, 4'h0, 1, 4'h1, 1, 2'd0, 0);
    add(1, 4'hF, 4'h0, 1, 4'h2, 1, 2'd1, 0);
    add(1, 4'h4, 4'h0, 1, 4'h4, 1, 2'd2, 0);        // rr_ptr -> 3
    add(1, 4'h8, 4'h0, 1, 4'h8, 1, 2'd3, 0);        // wrap to 0
    add(1, 4'h1, 4'h0, 1, 4'h1, 1, 2'd0, 0);
    add(1, 4'h3, 4'h0, 1, 4'h2, 1, 2'd1, 0);        // rr_ptr was 1
    add(1, 4'h6, 4'h0, 0, 4'h0, 1, 2'd1, 0);        // stall x3
    add(1, 4'h6, 4'h0, 0, 4'h0, 1, 2'd1, 0);
    add(1, 4'h6, 4'h0, 0, 4'h0, 1, 2'd1, 0);
    add(1, 4'h6, 4'h0, 1, 4'h4, 1, 2'd2, 0);        // drain+reload same cycle
    add(1, 4'h0, 4'h0, 1, 4'h0, 0, 2'd2, 0);        // drain only, payload kept
    add(1, 4'h2, 4'h0, 1, 4'h2, 1, 2'd1, 0);        // rr_ptr 3 -> 1 wins, ptr 2
    add(1, 4'hF, 4'h4, 1, 4'h4, 1, 2'd2, 1);        // lock beats 1,1,0
    add(1, 4'hF, 4'h4, 1, 4'h4, 1, 2'd2, 1);
    add(1, 4'hF, 4'h0, 1, 4'h4, 1, 2'd2, 0);
    add(1, 4'hF, 4'h0, 1, 4'h8, 1, 2'd3, 0);        // rr resumes at 3
    add(1, 4'h4, 4'h4, 1, 4'h4, 1, 2'd2, 1);        // relock on 2
    add(1, 4'hB, 4'h0, 1, 4'h0, 0, 2'd2, 1);        // holder idle, others stall
    add(1, 4'hB, 4'h0, 1, 4'h0, 0, 2'd2, 1);
    add(1, 4'h4, 4'h4, 0, 4'h4, 1, 2'd2, 1);        // ovld=0: out_rdy ignored
    add(0, 4'hF, 4'h0, 0, 4'h0, 0, 2'd0, 0);        // reset mid-lock, ovld=1
    add(1, 4'hE, 4'h0, 1, 4'h2, 1, 2'd1, 0);        // lowest valid after reset
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstn           = tbl[i].rstn;
      bus.req_vld_i  = tbl[i].vld;
      bus.req_lock_i = tbl[i].lock;
      bus.out_rdy_i  = tbl[i].ordy;
      #1;
      chk("req_rdy", i, W'(bus.req_rdy_o), W'(tbl[i].erdy));
      @(posedge clk);
      #1;
      chk("out_vld", i, W'(bus.out_vld_o), W'(tbl[i].eovld));
      chk("out_src", i, W'(bus.out_src_o), W'(tbl[i].esrc));
      chk("locked",  i, W'(bus.locked_o),  W'(tbl[i].elocked));
      chk("payload", i, bus.out_payload_o, tbl[i].epay);
      nvec++;
    end

    // free-running all-valid stream: one grant per cycle, source order from the table's end state
    for (int c = 0; c < 8; c++) begin
      logic [1:0] es;
`ifdef L1D_ARB_REQ0_PRIO_EN
      es = 2'd0;
`else
      es = 2'(2 + c);
`endif
      @(negedge clk);
      bus.req_vld_i  = 4'hF;
      bus.req_lock_i = 4'h0;
      bus.out_rdy_i  = 1'b1;
      #1;
      chk("one_rdy", 100 + c, W'($countones(bus.req_rdy_o)), W'(1));
      @(posedge clk);
      #1;
      chk("stream_src", 100 + c, W'(bus.out_src_o), W'(es));
      chk("stream_pay", 100 + c, bus.out_payload_o, pat(int'(es)));
      nvec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/l1d_bank_port_arb.md
Name: l1d_bank_port_arb

Overview:
- Round-robin arbiter that shares one L1D data-bank access port between N_REQ requesters, e.g. load pipe, store drain, refill and probe.
- Registers the winning request into a single output stage. Latency is 1 cycle; throughput is 1 request per cycle.
- Supports multi-beat locked grants, such as a refill line written over several beats.
- Sits between the requester queues and the bank read/write pipeline.

Parameters:
- N_REQ, 4, number of requesters; must be at least 2; need not be a power of 2.
- PAYLOAD_W, 64, width of each request payload (addr/data/cmd packed by the requester).
- IDX_W, $clog2(N_REQ), width of the requester index (derived).

Ports:
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- req_vld_i  input  N_REQ  per-requester valid
- req_lock_i  input  N_REQ  per-requester lock; sampled with the accepted beat
- req_payload_i  input  N_REQ*PAYLOAD_W  payloads packed flat; requester i occupies [i*PAYLOAD_W +: PAYLOAD_W]
- req_rdy_o  output  N_REQ  per-requester accept; at most one bit set
- out_vld_o  output  1  output stage holds a request
- out_payload_o  output  PAYLOAD_W  registered winning payload
- out_src_o  output  IDX_W  index of the requester that owns out_payload_o
- out_rdy_i  input  1  bank port consumes the output stage
- locked_o  output  1  a lock is currently held

Behaviour:
- Reset is synchronous. While rstn=0 at a clk edge:
  - out_vld_o=0, out_payload_o=0, out_src_o=0, locked_o=0.
  - rr_ptr=0, lock_idx=0.
  - req_rdy_o is held at 0 combinationally while rstn=0.
- can_accept = ~out_vld_q | out_rdy_i. The stage reloads in the same cycle it drains, so there is no bubble.
- Eligibility:
  - If locked_o=1, only requester lock_idx is eligible.
  - Otherwise every i with req_vld_i[i]=1 is eligible.
- Winner: the first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
- req_rdy_o[w]=1 only when can_accept=1, w is eligible and w is the winner. Requesters must hold valid and payload stable until they see rdy.
- Accept (req_vld_i[w] & req_rdy_o[w]), at the next edge:
  - out_vld_q=1, out_payload_q=payload[w], out_src_q=w.
  - rr_ptr = (w+1) mod N_REQ. When w=N_REQ-1, rr_ptr wraps to 0.
  - If req_lock_i[w]=1: locked_o=1, lock_idx=w.
  - If req_lock_i[w]=0: locked_o=0.
  - While locked, rr_ptr is still updated on every accept. Only the eligibility mask is restricted.
- Drain without accept: out_vld_q=1, out_rdy_i=1 and no accept → out_vld_q=0. Payload and src keep their old values.
- Stall: out_vld_q=1 and out_rdy_i=0 → the output stage holds, and all req_rdy_o are 0.
- Locked requester deasserts valid:
  - The lock persists and all other requesters stall.
  - The lock is released only by an accepted beat with req_lock_i=0, or by reset.
- No requests: rr_ptr holds and out_vld drains as above.
- Reset mid-lock or mid-stall: all state returns to reset values in one cycle. No request is lost silently; an un-consumed output request is dropped by design.
- out_rdy_i is ignored when out_vld_q=0.

Optional Feature:
- Macro L1D_ARB_REQ0_PRIO_EN.
- Defined:
  - Requester 0 (the refill path) wins whenever it is eligible, ahead of round-robin order.
  - When req0 is granted, rr_ptr is not updated.
  - Locks still take precedence: req0 cannot break another requester's lock.
- Undefined: pure round-robin, all requesters equal.

Test Plan:
- All 4 requesters valid continuously, out_rdy_i=1, no lock → out_src_o sequence 0,1,2,3,0,1; exactly one req_rdy_o per cycle; out_vld_o=1 from cycle 1 onward.
- Only req 3 valid after rr_ptr=3, then only req 0 → grants 3 then 0. Checks wrap; rr_ptr=1 afterwards.
- out_rdy_i=0 for 3 cycles with req 1 and req 2 valid → out_payload_o stable and req_rdy_o=0 throughout; on out_rdy_i=1, the next request is accepted the same cycle with no bubble.
- Req 2 lock beats: lock=1,1,0 while reqs 0, 1 and 3 are valid → outputs 2,2,2 then round-robin resumes at 3; locked_o=1 for exactly the cycles between the first and last beat.
- rstn=0 for one cycle while locked with out_vld_o=1 → next cycle out_vld_o=0, locked_o=0, rr_ptr=0; first grant after reset goes to the lowest valid index.
- With L1D_ARB_REQ0_PRIO_EN, all valid → req 0 granted every cycle; rr_ptr unchanged. Without the macro, the same stimulus yields 0,1,2,3.
